// File: rtl/gfsk_iq_stim_if.sv
// -----------------------------------------------------------------------------
// gfsk_iq_stim_if
//   Bundles the symbol/configuration inputs and the I/Q sample outputs of the
//   GFSK I/Q stimulus generator.
//
//   master : drives sym_in, cfg_mode, cfg_fcw; observes the sample outputs
//   slave  : the generator itself
//
//   sym_in    modulator symbol (io_gfskout)
//   cfg_mode  0 = track, 1 = free-run, 2 = fixed tone, 3 = off
//   cfg_fcw   frequency control word used in fixed-tone mode
//   io_isig   I sample, offset binary
//   io_qsig   Q sample, offset binary
//   out_valid one-cycle pulse per new I/Q pair
//   armed     tracking mode armed (also high in free-run / fixed tone)
// -----------------------------------------------------------------------------
interface gfsk_iq_stim_if #(
   parameter int SAMPLE_W = 5,
   parameter int PHASE_W  = 16,
   parameter int SYM_W    = 3
);
   logic [SYM_W-1:0]    sym_in;
   logic [1:0]          cfg_mode;
   logic [PHASE_W-1:0]  cfg_fcw;
   logic [SAMPLE_W-1:0] io_isig;
   logic [SAMPLE_W-1:0] io_qsig;
   logic                out_valid;
   logic                armed;

   modport master (
      output sym_in, cfg_mode, cfg_fcw,
      input  io_isig, io_qsig, out_valid, armed
   );

   modport slave (
      input  sym_in, cfg_mode, cfg_fcw,
      output io_isig, io_qsig, out_valid, armed
   );
endinterface

// File: rtl/gfsk_iq_stim.sv
// -----------------------------------------------------------------------------
// gfsk_iq_stim
//   I/Q baseband stimulus generator for the GFSK demodulator path. An NCO whose
//   frequency follows the modulator symbol (or a fixed FCW) drives a
//   quarter-wave sine LUT; sine goes out on I, cosine on Q.
//
//   clock  sample-domain clock
//   reset  synchronous, active-high reset
//   bus    gfsk_iq_stim_if.slave (symbol / mode / FCW in, I/Q samples out)
//
//   Pipeline: emitting tick -> stage 1 (quadrant + LUT magnitude)
//             -> stage 2 (offset-binary outputs + out_valid), 2 clocks latency.
// -----------------------------------------------------------------------------
module gfsk_iq_stim #(
   parameter int SAMPLE_W   = 5,
   parameter int PHASE_W    = 16,
   parameter int SYM_W      = 3,
   parameter int LUT_ADDR_W = 6,
   parameter int AMP        = 10,
   parameter int DIV        = 1,
   parameter int BASE_FCW   = 3686,
   parameter int STEP_FCW   = 102
) (
   input  logic          clock,
   input  logic          reset,
   gfsk_iq_stim_if.slave bus
);

   localparam int  N     = 2 ** LUT_ADDR_W;
   localparam int  MID   = 2 ** (SAMPLE_W - 1);
   localparam int  MAG_W = SAMPLE_W - 1;
   localparam int  DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam real PI    = 3.14159265358979323846;

   localparam logic [PHASE_W-1:0]  BASE_W   = PHASE_W'(BASE_FCW);
   localparam logic [PHASE_W-1:0]  STEP_W   = PHASE_W'(STEP_FCW);
   localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [SAMPLE_W-1:0] MID_S    = SAMPLE_W'(MID);

   localparam logic [1:0] MODE_TRACK = 2'd0;
   localparam logic [1:0] MODE_FREE  = 2'd1;
   localparam logic [1:0] MODE_FIXED = 2'd2;
   localparam logic [1:0] MODE_OFF   = 2'd3;

   if (AMP > MID - 1) begin : g_bad_amp
      $error("gfsk_iq_stim: AMP=%0d exceeds MID-1=%0d", AMP, MID - 1);
   end
   if (PHASE_W < LUT_ADDR_W + 2) begin : g_bad_phase_w
      $error("gfsk_iq_stim: PHASE_W=%0d must be >= LUT_ADDR_W+2", PHASE_W);
   end
   if (DIV < 1) begin : g_bad_div
      $error("gfsk_iq_stim: DIV=%0d must be >= 1", DIV);
   end

   typedef struct packed {
      logic             neg;
      logic [MAG_W-1:0] mag;
   } half_t;

   // Entries sit at the centre of each LUT bin, so no entry is exactly 0 or AMP
   // and the quarter wave mirrors cleanly with ~index.
   function automatic logic [MAG_W-1:0] lut_entry(input int k);
      real x;
      x = real'(AMP) * $sin(PI / 2.0 * real'(2 * k + 1) / real'(2 * N));
      return MAG_W'($rtoi(x + 0.5));
   endfunction

   function automatic logic [SAMPLE_W-1:0] to_offset(input half_t h);
      return h.neg ? MID_S - {1'b0, h.mag} : MID_S + {1'b0, h.mag};
   endfunction

   // NOTE: the LUT is a constant table, not storage, so it needs no reset.
   logic [MAG_W-1:0] lut [N];
   for (genvar k = 0; k < N; k++) begin : g_lut
      localparam logic [MAG_W-1:0] ENTRY = lut_entry(k);
      assign lut[k] = ENTRY;
   end

   logic [1:0]            mode_q,     mode_d;
   logic [DIV_W-1:0]      div_q,      div_d;
   logic [PHASE_W-1:0]    phase_q,    phase_d;
   logic                  armed_q,    armed_d;
   logic                  s1_valid_q, s1_valid_d;
   half_t                 s1_sin_q,   s1_sin_d;
   half_t                 s1_cos_q,   s1_cos_d;
   logic [SAMPLE_W-1:0]   isig_q,     isig_d;
   logic [SAMPLE_W-1:0]   qsig_q,     qsig_d;
   logic                  valid_q,    valid_d;

   logic                  mode_change;
   logic                  tick;
   logic                  emit;
   logic                  arm_set;
   logic [PHASE_W-1:0]    fcw;
   logic [1:0]            sin_quad;
   logic [1:0]            cos_quad;
   logic [LUT_ADDR_W-1:0] idx;
   half_t                 sin_look;
   half_t                 cos_look;

   assign mode_change = (bus.cfg_mode != mode_q);
   assign tick        = (div_q == DIV_LAST);

   // A mode change on the same edge as a tick suppresses the tick entirely.
   assign emit    = tick && !mode_change &&
                    ((mode_q == MODE_TRACK && armed_q) ||
                     mode_q == MODE_FREE || mode_q == MODE_FIXED);
   assign arm_set = tick && !mode_change && mode_q == MODE_TRACK &&
                    !armed_q && (bus.sym_in != '0);

   assign fcw = (mode_q == MODE_FIXED) ? bus.cfg_fcw
                                       : BASE_W + PHASE_W'(bus.sym_in) * STEP_W;

   // Cosine is sine a quarter turn ahead; adding a quarter only moves the
   // quadrant bits, the LUT index is shared.
   assign sin_quad = phase_q[PHASE_W-1 -: 2];
   assign cos_quad = sin_quad + 2'd1;
   assign idx      = phase_q[PHASE_W-3 -: LUT_ADDR_W];

   // Odd quadrants read the quarter wave backwards; N-1-i is simply ~i.
   assign sin_look.neg = sin_quad[1];
   assign sin_look.mag = lut[sin_quad[0] ? ~idx : idx];
   assign cos_look.neg = cos_quad[1];
   assign cos_look.mag = lut[cos_quad[0] ? ~idx : idx];

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path infers a latch.
      mode_d     = mode_q;
      div_d      = div_q;
      phase_d    = phase_q;
      armed_d    = armed_q;
      s1_valid_d = 1'b0;
      s1_sin_d   = s1_sin_q;
      s1_cos_d   = s1_cos_q;
      isig_d     = isig_q;
      qsig_d     = qsig_q;
      valid_d    = 1'b0;

      if (mode_change) begin
         // Restart from phase 0 and drop whatever is still in the pipeline.
         mode_d  = bus.cfg_mode;
         div_d   = '0;
         phase_d = '0;
         armed_d = 1'b0;
         isig_d  = MID_S;
         qsig_d  = MID_S;
      end else begin
         div_d = tick ? '0 : div_q + 1'b1;

         if (arm_set || mode_q == MODE_FREE || mode_q == MODE_FIXED) begin
            armed_d = 1'b1;
         end

         // The sample uses the pre-increment phase.
         if (emit) begin
            phase_d    = phase_q + fcw;
            s1_valid_d = 1'b1;
            s1_sin_d   = sin_look;
            s1_cos_d   = cos_look;
         end

         if (s1_valid_q) begin
            valid_d = 1'b1;
            isig_d  = to_offset(s1_sin_q);
            qsig_d  = to_offset(s1_cos_q);
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // sees pre-edge values regardless of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         mode_q     <= bus.cfg_mode;
         div_q      <= '0;
         phase_q    <= '0;
         armed_q    <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_sin_q   <= '0;
         s1_cos_q   <= '0;
         isig_q     <= MID_S;
         qsig_q     <= MID_S;
         valid_q    <= 1'b0;
      end else begin
         mode_q     <= mode_d;
         div_q      <= div_d;
         phase_q    <= phase_d;
         armed_q    <= armed_d;
         s1_valid_q <= s1_valid_d;
         s1_sin_q   <= s1_sin_d;
         s1_cos_q   <= s1_cos_d;
         isig_q     <= isig_d;
         qsig_q     <= qsig_d;
         valid_q    <= valid_d;
      end
   end

   assign bus.io_isig   = isig_q;
   assign bus.io_qsig   = qsig_q;
   assign bus.out_valid = valid_q;
   assign bus.armed     = armed_q;

   // MODE_OFF needs no explicit branch: it never emits and never arms.
   logic unused_mode_off;
   assign unused_mode_off = (mode_q == MODE_OFF);

endmodule

// File: doc/gfsk_iq_stim.md
# gfsk_iq_stim

Synthesizable, parametrised I/Q baseband stimulus generator for the GFSK demodulator path. It replaces the behavioural real-valued tone model in the top-level bench. It closes the modulator-to-demodulator loop on-chip or in gate-level simulation, driving `io_isig`/`io_qsig` from an NCO whose frequency is set by the modulator's symbol output (`io_gfskout`). It adds selectable modes (tracking with arm-on-first-symbol, free-run, fixed tone, off), a configurable sample-rate divider, and a quarter-wave sine LUT.

## Interface
Parameters:
- SAMPLE_W, 5: I/Q output width; midscale MID = 2^(SAMPLE_W-1).
- PHASE_W, 16: phase accumulator width (≥ LUT_ADDR_W+2).
- SYM_W, 3: symbol input width.
- LUT_ADDR_W, 6: quarter-wave LUT address width; N = 2^LUT_ADDR_W entries.
- AMP, 10: peak amplitude in LSBs. Must be ≤ MID-1; elaboration error otherwise.
- DIV, 1: clock cycles per output sample (≥1).
- BASE_FCW, 3686: frequency control word for symbol 0 (2.25 MHz at 40 MHz sample rate).
- STEP_FCW, 102: FCW increment per symbol LSB (62.5 kHz).

Ports:
- clock  in  1  sample-domain clock (40 MHz).
- reset  in  1  synchronous, active-high reset.
- sym_in  in  SYM_W  modulator symbol (`io_gfskout`).
- cfg_mode  in  2  0 = track, 1 = free-run, 2 = fixed tone, 3 = off.
- cfg_fcw  in  PHASE_W  FCW used in mode 2.
- io_isig  out  SAMPLE_W  I sample (offset binary).
- io_qsig  out  SAMPLE_W  Q sample (offset binary).
- out_valid  out  1  one-cycle pulse when a new I/Q pair is presented.
- armed  out  1  high while mode 0 is armed; also high in modes 1 and 2.

## Operation
- Reset values: io_isig = io_qsig = MID, out_valid = 0, armed = 0, phase = 0, divider = 0, pipeline valid = 0, cfg_mode_q = cfg_mode.
- Divider: counts 0..DIV-1. A tick occurs in the cycle where count == DIV-1, and the count then wraps to 0. DIV = 1 gives a tick every cycle.
- FCW: `fcw = (BASE_FCW + sym_in*STEP_FCW) mod 2^PHASE_W` in modes 0 and 1; `fcw = cfg_fcw` in mode 2. sym_in is sampled only on ticks.
- Phase accumulator: on an emitting tick, `phase <= (phase + fcw) mod 2^PHASE_W`. Wrap-around is natural modular overflow with no correction.
- Emitting tick by mode:
  - Mode 0, unarmed: a tick with sym_in ≠ 0 sets armed. That tick does not advance phase and emits nothing. Ticks with sym_in = 0 do nothing; outputs hold MID.
  - Mode 0, armed; modes 1 and 2: every tick emits.
  - Mode 3: no ticks emit; outputs hold MID and phase holds 0.
- Armed: cleared only by reset or a mode change.
- Sample uses the pre-increment phase, so the first sample after arming, reset or a mode change is at phase 0.
- Sine lookup:
  - Quadrant q = phase[PHASE_W-1:PHASE_W-2]; index i = the next LUT_ADDR_W bits.
  - `LUT[k] = round(AMP*sin(pi/2*(2k+1)/(2N)))`, unsigned.
  - Magnitude: q0 = +LUT[i], q1 = +LUT[N-1-i], q2 = -LUT[i], q3 = -LUT[N-1-i].
  - Output = MID + magnitude. The result never over- or under-flows given the AMP constraint.
- Cosine: the same lookup on `phase + 2^(PHASE_W-2)`, modulo 2^PHASE_W.
- Mode change: when cfg_mode ≠ cfg_mode_q at a clock edge:
  - phase, divider, armed and pipeline valid are cleared;
  - cfg_mode_q is updated;
  - on the next edge io_isig/io_qsig return to MID and out_valid = 0;
  - any in-flight sample is discarded.
- Reset mid-operation: all state returns to reset values at that edge, and in-flight samples are discarded.

## Timing
- Emitting tick in cycle t:
  - edge t: stage-1 register captures quadrant/magnitude for sin and cos; phase advances.
  - edge t+1: io_isig/io_qsig update and out_valid pulses high for exactly cycle t+1→t+2.
- Latency: 2 clocks from tick to valid output. Outputs hold between pulses.
- Throughput: one sample per DIV cycles; out_valid is continuously high when DIV = 1.
- First tick after reset release: cycle DIV-1, where cycle 0 is the first cycle with reset low.
- Simultaneous mode change and tick: the mode change wins; no phase update and no sample.

## Test plan
- Reset: hold reset 5 cycles, then release in mode 0 with sym_in = 0 for 20 cycles → io_isig = io_qsig = 16, out_valid = 0, armed = 0 throughout.
- Quadrant sweep: mode 2, DIV = 1, cfg_fcw = 16384 → out_valid high from cycle 2; (I,Q) sequence (16,26),(26,16),(16,6),(6,16), repeating.
- Tracking arm: mode 0, DIV = 1, sym_in = 0 for 10 cycles then 1 → armed rises one edge after the first nonzero tick. The first sample is (16,26) two cycles later. Phase then advances by 3788 per cycle (checked via the I/Q trajectory against a reference model).
- Divider: mode 2, DIV = 4, cfg_fcw = 16384 → out_valid pulses every 4th cycle; the first pulse is at cycle 5 (first tick at cycle 3, plus 2 cycles latency). Same sequence as the quadrant sweep.
- Wrap-around: mode 1, sym_in = 7 (fcw = 4400), run 100 samples → phase wraps modulo 65536 with no glitch; every sample matches the model; all values lie in 6..26.
- Mode change / reset mid-stream: mid-sweep, switch mode 2→3 → outputs return to 16/16 on the next edge with out_valid = 0. Switch back to 2 → restarts at (16,26). Assert reset mid-stream → all outputs at reset values on the next edge.
